drum_xfer_ctl: RTL and testbench
================================

DRUM_XFER_CTL -- requirements
Module: drum_xfer_ctl

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: CLOCK in 1 (system bit clock, one bit time per cycle); RESET in 1 (synchronous, active-high).
REQ-002 SHALL provide requester A (DA-1, priority on reset): A_REQ in 1 (level request); A_WR in 1 (1 = write, 0 = read); A_LINE in 5 (line 7..18); A_WORD in 7 (word 0..107).
REQ-003 SHALL provide requester A handshake outputs: A_ACK out 1 (one-cycle grant pulse); A_DONE out 1 (one-cycle completion pulse); A_ERR out 1 (one-cycle reject pulse).
REQ-004 SHALL provide requester C (CPU) ports identical to REQ-002/003, prefixed C_.
REQ-005 SHALL provide outputs D1, D2, D3, D4, DU, DV, DW, DX, each out 1: write-destination decode for the line being transferred.
REQ-006 SHALL provide outputs S1, S2, S3, S4, SU, SV, SW, SX, each out 1: read-source decode for the line being transferred.
REQ-007 SHALL provide TR out 1 (transfer-enable during the write word); BT out 5 (bit time 0..28); WT out 7 (word time 0..107); BUSY out 1.

Function
REQ-008 SHALL count BT 0..28 every cycle; WT SHALL advance on BT 28->0 and wrap 107->0; one revolution is 3132 cycles, phase-locked to drum_track N=3132.
REQ-009 SHALL run a state machine IDLE -> WAIT -> XFER -> IDLE.
REQ-010 In IDLE with any REQ high, SHALL arbitrate round-robin.
REQ-011 Round-robin SHALL grant the requester not granted last; after reset, A wins a simultaneous request.
REQ-012 On grant, SHALL latch WR, LINE and WORD, pulse that requester's ACK for one cycle, and enter WAIT.
REQ-013 A granted request with LINE outside 7..18 or WORD > 107 SHALL pulse ERR instead of ACK.
REQ-014 On a rejected request, SHALL stay in IDLE, and SHALL not drive any decode output.
REQ-015 WAIT SHALL enter XFER on the cycle where BT = 28 and WT = (WORD-1) mod 108, so WORD 0 matches WT 107.
REQ-016 XFER SHALL last exactly 29 cycles, BT 0..28 of word WT = WORD.
REQ-017 Line decode: group g = LINE div 4 selects D/S g; LINE mod 4 selects U (0), V (1), W (2), X (3).
REQ-018 Decode examples: line 7 -> 1/X; line 8 -> 2/U; line 18 -> 4/W.
REQ-019 During XFER, writes SHALL assert the D pair plus TR; reads SHALL assert the S pair only.
REQ-020 Outside XFER, all D*, S* and TR SHALL be 0.
REQ-021 Decode outputs SHALL be registered, and SHALL be valid from the first XFER cycle.
REQ-022 DONE SHALL pulse in the cycle after the last XFER cycle (BT 0 of WORD+1); the state SHALL return to IDLE that cycle.
REQ-023 Arbitration for the next request SHALL occur the following cycle.
REQ-024 REQ deasserted after ACK SHALL NOT cancel the transfer.
REQ-025 A requester SHALL hold REQ low after DONE for at least one cycle, or it is re-granted.
REQ-026 A request granted while BT = 28 and WT = WORD-1 SHALL wait a full revolution (match evaluated only from the cycle after ACK).
REQ-027 BUSY SHALL equal (state != IDLE).

Reset
REQ-028 On RESET high at a clock edge: BT=0, WT=0, state=IDLE, round-robin pointer favours A.
REQ-029 On RESET, all ACK/DONE/ERR/D*/S*/TR/BUSY SHALL be 0 from the next cycle.
REQ-030 Reset mid-XFER SHALL abort without DONE.
REQ-031 Reset SHALL override all other events in the same cycle.

Structure
REQ-032 Package g15_drum_pkg SHALL hold BITS_PER_WORD=29, WORDS_PER_TRACK=108, LINE_MIN=7, LINE_MAX=18, and the xfer_state_t enum.
REQ-033 One sub-module drum_timer SHALL hold the BT/WT counters.
REQ-034 Arbitration, FSM and decode SHALL reside in drum_xfer_ctl.

Verification
REQ-035 Reset then 3132 cycles -> BT/WT return to 0/0; WT reaches 107 at cycle 3103.
REQ-036 C write line 8 word 5 from reset -> C_ACK at cycle 1, XFER cycles 145..173 with D2, DU, TR high, C_DONE at 174.
REQ-037 A and C request together after reset -> A granted first; C granted the cycle after A_DONE; a third simultaneous pair grants C first.
REQ-038 A read line 18 word 0 -> S4, SW high during WT 0 of the next revolution; D* and TR stay 0.
REQ-039 C request line 19, then word 108 -> C_ERR pulse each, no ACK, BUSY stays 0.
REQ-040 RESET asserted at XFER BT 10 -> next cycle all outputs 0, no DONE, BT=0, WT=0.

Source files
------------

// File: rtl/g15_drum_pkg.sv
// -----------------------------------------------------------------------------
// g15_drum_pkg
// Shared drum geometry constants, the transfer FSM state type and the
// line-number to destination/source decode helper used by drum_xfer_ctl.
//
// Geometry: 29 bit times per word, 108 words per track, so one drum
// revolution is 29 * 108 = 3132 bit-clock cycles.
// Addressable lines for transfers: 7..18 inclusive.
// -----------------------------------------------------------------------------
package g15_drum_pkg;

    localparam logic [4:0] BITS_PER_WORD   = 5'd29;
    localparam logic [6:0] WORDS_PER_TRACK = 7'd108;
    localparam logic [4:0] LINE_MIN        = 5'd7;
    localparam logic [4:0] LINE_MAX        = 5'd18;

    // Last bit time in a word and last word time in a track.
    localparam logic [4:0] BT_LAST = BITS_PER_WORD - 5'd1;
    localparam logic [6:0] WT_LAST = WORDS_PER_TRACK - 7'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2
    } xfer_state_t;

    // Decode a line number into {grp1, grp2, grp3, grp4, U, V, W, X}.
    // The group is line div 4 and the letter is line mod 4, so line 7 is
    // 1/X, line 8 is 2/U and line 18 is 4/W.
    function automatic logic [7:0] line_decode(input logic [4:0] line);
        logic [7:0] dec;
        dec = 8'b0;
        case (line[4:2])
            3'd1:    dec[7] = 1'b1;
            3'd2:    dec[6] = 1'b1;
            3'd3:    dec[5] = 1'b1;
            3'd4:    dec[4] = 1'b1;
            default: dec[7:4] = 4'b0;
        endcase
        case (line[1:0])
            2'd0:    dec[3] = 1'b1;
            2'd1:    dec[2] = 1'b1;
            2'd2:    dec[1] = 1'b1;
            default: dec[0] = 1'b1;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/drum_timer.sv
// -----------------------------------------------------------------------------
// drum_timer
// Bit-time / word-time counters phase-locked to the drum track.
// BT counts 0..28 every cycle; WT advances when BT wraps 28->0 and itself
// wraps 107->0, giving one revolution every 3132 cycles.
//
// Ports:
//   clk_i  in  1  bit clock
//   rst_i  in  1  synchronous active-high reset (BT=0, WT=0)
//   bt_o   out 5  current bit time 0..28
//   wt_o   out 7  current word time 0..107
// -----------------------------------------------------------------------------
module drum_timer
    import g15_drum_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [4:0] bt_o,
    output logic [6:0] wt_o
);

    logic [4:0] bt_q, bt_d;
    logic [6:0] wt_q, wt_d;

    always_comb begin
        bt_d = bt_q + 5'd1;
        wt_d = wt_q;
        if (bt_q == BT_LAST) begin
            bt_d = 5'd0;
            wt_d = (wt_q == WT_LAST) ? 7'd0 : wt_q + 7'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bt_q <= 5'd0;
            wt_q <= 7'd0;
        end else begin
            bt_q <= bt_d;
            wt_q <= wt_d;
        end
    end

    assign bt_o = bt_q;
    assign wt_o = wt_q;

endmodule

// File: rtl/drum_xfer_ctl.sv
// -----------------------------------------------------------------------------
// drum_xfer_ctl
// Drum transfer controller for two requesters (A = DA-1, C = CPU).
// A request is arbitrated round-robin while idle, acknowledged (or rejected
// with ERR when the line/word is out of range), then waits for the addressed
// word to come under the heads and performs a one-word (29 cycle) transfer,
// driving the registered line decode. DONE pulses on the cycle after the
// last transfer bit.
//
// Request/handshake semantics: REQ is a level; it is sampled only while
// BUSY is low. The grant is signalled by a one-cycle ACK (or ERR) on the
// following cycle; dropping REQ after ACK does not cancel the transfer, and
// a requester that keeps REQ high on the DONE cycle is granted again.
//
// Ports:
//   CLOCK, RESET                  bit clock, synchronous active-high reset
//   A_REQ/A_WR/A_LINE/A_WORD      requester A request, direction, address
//   A_ACK/A_DONE/A_ERR            requester A one-cycle pulses
//   C_*                           requester C, same as A
//   D1..D4, DU..DX                write-destination decode (during XFER)
//   S1..S4, SU..SX                read-source decode (during XFER)
//   TR                            transfer enable, writes only
//   BT, WT                        drum bit time / word time
//   BUSY                          controller not idle
//   DBG_STATE                     current FSM state (debug observation)
// -----------------------------------------------------------------------------
module drum_xfer_ctl
    import g15_drum_pkg::*;
(
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        A_REQ,
    input  logic        A_WR,
    input  logic [4:0]  A_LINE,
    input  logic [6:0]  A_WORD,
    output logic        A_ACK,
    output logic        A_DONE,
    output logic        A_ERR,
    input  logic        C_REQ,
    input  logic        C_WR,
    input  logic [4:0]  C_LINE,
    input  logic [6:0]  C_WORD,
    output logic        C_ACK,
    output logic        C_DONE,
    output logic        C_ERR,
    output logic        D1,
    output logic        D2,
    output logic        D3,
    output logic        D4,
    output logic        DU,
    output logic        DV,
    output logic        DW,
    output logic        DX,
    output logic        S1,
    output logic        S2,
    output logic        S3,
    output logic        S4,
    output logic        SU,
    output logic        SV,
    output logic        SW,
    output logic        SX,
    output logic        TR,
    output logic [4:0]  BT,
    output logic [6:0]  WT,
    output logic        BUSY,
    output xfer_state_t DBG_STATE
);

    logic [4:0] bt;
    logic [6:0] wt;

    drum_timer u_timer (
        .clk_i (CLOCK),
        .rst_i (RESET),
        .bt_o  (bt),
        .wt_o  (wt)
    );

    xfer_state_t state_q, state_d;
    logic        prefer_a_q, prefer_a_d;   // 1: A wins a simultaneous request
    logic        owner_c_q, owner_c_d;     // 1: current transfer belongs to C
    logic        wr_q, wr_d;
    logic [4:0]  line_q, line_d;
    logic [6:0]  word_q, word_d;
    logic        a_ack_q, a_ack_d, a_done_q, a_done_d, a_err_q, a_err_d;
    logic        c_ack_q, c_ack_d, c_done_q, c_done_d, c_err_q, c_err_d;
    logic [7:0]  dst_q, dst_d, src_q, src_d;
    logic        tr_q, tr_d;

    // Arbitration winner and its request fields.
    logic        pick_c;
    logic        req_wr;
    logic [4:0]  req_line;
    logic [6:0]  req_word;
    logic        req_ok;
    logic [6:0]  match_wt;
    logic        at_match;
    logic [7:0]  dec;

    assign pick_c   = C_REQ && (!A_REQ || !prefer_a_q);
    assign req_wr   = pick_c ? C_WR   : A_WR;
    assign req_line = pick_c ? C_LINE : A_LINE;
    assign req_word = pick_c ? C_WORD : A_WORD;
    assign req_ok   = (req_line >= LINE_MIN) && (req_line <= LINE_MAX) &&
                      (req_word <= WT_LAST);

    // The transfer starts on the cycle after the last bit of the preceding
    // word, so the match is on BT 28 of word (WORD-1) mod 108.
    assign match_wt = (word_q == 7'd0) ? WT_LAST : word_q - 7'd1;
    assign at_match = (bt == BT_LAST) && (wt == match_wt);
    assign dec      = line_decode(line_q);

    always_comb begin
        state_d    = state_q;
        prefer_a_d = prefer_a_q;
        owner_c_d  = owner_c_q;
        wr_d       = wr_q;
        line_d     = line_q;
        word_d     = word_q;
        a_ack_d    = 1'b0;
        a_done_d   = 1'b0;
        a_err_d    = 1'b0;
        c_ack_d    = 1'b0;
        c_done_d   = 1'b0;
        c_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (A_REQ || C_REQ) begin
                    // A rejected request still counts as a grant for fairness.
                    prefer_a_d = pick_c;
                    if (req_ok) begin
                        owner_c_d = pick_c;
                        wr_d      = req_wr;
                        line_d    = req_line;
                        word_d    = req_word;
                        a_ack_d   = !pick_c;
                        c_ack_d   = pick_c;
                        state_d   = ST_WAIT;
                    end else begin
                        a_err_d = !pick_c;
                        c_err_d = pick_c;
                    end
                end
            end
            ST_WAIT: begin
                if (at_match) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (bt == BT_LAST) begin
                    state_d  = ST_IDLE;
                    a_done_d = !owner_c_q;
                    c_done_d = owner_c_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Decode is registered from the next state so it is valid on the
        // first XFER cycle and clears on the DONE cycle.
        dst_d = ((state_d == ST_XFER) &&  wr_q) ? dec : 8'b0;
        src_d = ((state_d == ST_XFER) && !wr_q) ? dec : 8'b0;
        tr_d  = (state_d == ST_XFER) && wr_q;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            prefer_a_q <= 1'b1;
            owner_c_q  <= 1'b0;
            wr_q       <= 1'b0;
            line_q     <= 5'd0;
            word_q     <= 7'd0;
            a_ack_q    <= 1'b0;
            a_done_q   <= 1'b0;
            a_err_q    <= 1'b0;
            c_ack_q    <= 1'b0;
            c_done_q   <= 1'b0;
            c_err_q    <= 1'b0;
            dst_q      <= 8'b0;
            src_q      <= 8'b0;
            tr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            prefer_a_q <= prefer_a_d;
            owner_c_q  <= owner_c_d;
            wr_q       <= wr_d;
            line_q     <= line_d;
            word_q     <= word_d;
            a_ack_q    <= a_ack_d;
            a_done_q   <= a_done_d;
            a_err_q    <= a_err_d;
            c_ack_q    <= c_ack_d;
            c_done_q   <= c_done_d;
            c_err_q    <= c_err_d;
            dst_q      <= dst_d;
            src_q      <= src_d;
            tr_q       <= tr_d;
        end
    end

    assign A_ACK  = a_ack_q;
    assign A_DONE = a_done_q;
    assign A_ERR  = a_err_q;
    assign C_ACK  = c_ack_q;
    assign C_DONE = c_done_q;
    assign C_ERR  = c_err_q;

    assign {D1, D2, D3, D4, DU, DV, DW, DX} = dst_q;
    assign {S1, S2, S3, S4, SU, SV, SW, SX} = src_q;
    assign TR = tr_q;

    assign BT        = bt;
    assign WT        = wt;
    assign BUSY      = (state_q != ST_IDLE);
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_drum_xfer_ctl.sv
module tb_drum_xfer_ctl;
    import g15_drum_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        A_REQ, A_WR, C_REQ, C_WR;
    logic [4:0]  A_LINE, C_LINE;
    logic [6:0]  A_WORD, C_WORD;
    logic        A_ACK, A_DONE, A_ERR, C_ACK, C_DONE, C_ERR;
    logic        D1, D2, D3, D4, DU, DV, DW, DX;
    logic        S1, S2, S3, S4, SU, SV, SW, SX;
    logic        TR, BUSY;
    logic [4:0]  BT;
    logic [6:0]  WT;
    xfer_state_t DBG_STATE;

    always #5 CLOCK = ~CLOCK;

    drum_xfer_ctl dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .A_REQ(A_REQ), .A_WR(A_WR), .A_LINE(A_LINE), .A_WORD(A_WORD),
        .A_ACK(A_ACK), .A_DONE(A_DONE), .A_ERR(A_ERR),
        .C_REQ(C_REQ), .C_WR(C_WR), .C_LINE(C_LINE), .C_WORD(C_WORD),
        .C_ACK(C_ACK), .C_DONE(C_DONE), .C_ERR(C_ERR),
        .D1(D1), .D2(D2), .D3(D3), .D4(D4), .DU(DU), .DV(DV), .DW(DW), .DX(DX),
        .S1(S1), .S2(S2), .S3(S3), .S4(S4), .SU(SU), .SV(SV), .SW(SW), .SX(SX),
        .TR(TR), .BT(BT), .WT(WT), .BUSY(BUSY), .DBG_STATE(DBG_STATE)
    );

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- reference model (transaction level) ----------------
    // n is the cycle number since the reset edge; drum position follows
    // directly from it. Each accepted request is turned into absolute cycle
    // numbers for ACK/ERR, the transfer window and DONE.
    int n;
    int m_ack[2], m_err[2], m_done[2];
    int m_busy_from, m_free_at, m_xs, m_xe;
    int m_line;
    bit m_wr;
    int m_last;   // requester granted last: 0 = A, 1 = C

    function automatic logic [7:0] exp_decode(int line);
        logic [7:0] v;
        v = 8'b0;
        v[8 - line / 4] = 1'b1;
        v[3 - line % 4] = 1'b1;
        return v;
    endfunction

    // First cycle >= from that is bit 0 of the given word.
    function automatic int next_start(int from, int word);
        for (int s = from; s < from + 3300; s++)
            if ((s % 29 == 0) && ((s / 29) % 108 == word)) return s;
        return -1000;
    endfunction

    function automatic int near_word(int ahead);
        return ((n / 29) + ahead) % 108;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_ack[i] = -1; m_err[i] = -1; m_done[i] = -1;
        end
        m_busy_from = -1;
        m_free_at   = 0;
        m_xs        = -1;
        m_xe        = -2;
        m_line      = 7;
        m_wr        = 1'b0;
        m_last      = 1;
    endtask

    // Called with the inputs of cycle n, before the edge that ends it.
    task automatic model_edge();
        int who, line, word;
        bit wr;
        if (n >= m_free_at && (A_REQ || C_REQ)) begin
            if (A_REQ && C_REQ) who = 1 - m_last;
            else                who = A_REQ ? 0 : 1;
            line = (who == 0) ? int'(A_LINE) : int'(C_LINE);
            word = (who == 0) ? int'(A_WORD) : int'(C_WORD);
            wr   = (who == 0) ? A_WR : C_WR;
            m_last = who;
            if (line >= 7 && line <= 18 && word <= 107) begin
                m_ack[who]  = n + 1;
                m_busy_from = n + 1;
                // Match is only looked for from the cycle after ACK.
                m_xs        = next_start(n + 2, word);
                m_xe        = m_xs + 28;
                m_free_at   = m_xs + 29;
                m_done[who] = m_xs + 29;
                m_wr        = wr;
                m_line      = line;
            end else begin
                m_err[who] = n + 1;
            end
        end
    endtask

    // ---------------- scoreboard checks ----------------
    task automatic check();
        logic [11:0] exp_pos, obs_pos;
        logic [5:0]  exp_hs, obs_hs;
        logic [17:0] exp_dec, obs_dec;
        bit          xfer, busy;
        logic [7:0]  dv;
        xfer = (n >= m_xs) && (n <= m_xe);
        busy = (n >= m_busy_from) && (n < m_free_at);
        dv   = exp_decode(m_line);
        exp_pos = {5'(n % 29), 7'((n / 29) % 108)};
        obs_pos = {BT, WT};
        exp_hs  = {n == m_ack[0], n == m_done[0], n == m_err[0],
                   n == m_ack[1], n == m_done[1], n == m_err[1]};
        obs_hs  = {A_ACK, A_DONE, A_ERR, C_ACK, C_DONE, C_ERR};
        exp_dec = {(xfer && m_wr) ? dv : 8'b0, (xfer && !m_wr) ? dv : 8'b0,
                   xfer && m_wr, busy};
        obs_dec = {D1, D2, D3, D4, DU, DV, DW, DX, S1, S2, S3, S4, SU, SV, SW, SX, TR, BUSY};

        vectors++;
        assert (obs_pos === exp_pos) else begin
            miscompares++;
            $error("FAIL bt_wt cyc=%0d: got %h expected %h", n, obs_pos, exp_pos);
        end
        vectors++;
        assert (obs_hs === exp_hs) else begin
            miscompares++;
            $error("FAIL handshake cyc=%0d: got %b expected %b", n, obs_hs, exp_hs);
        end
        vectors++;
        assert (obs_dec === exp_dec) else begin
            miscompares++;
            $error("FAIL decode_busy cyc=%0d: got %b expected %b", n, obs_dec, exp_dec);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        model_edge();
        @(posedge CLOCK);
        n++;
        #1;
        check();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        A_REQ = 1'b0;
        C_REQ = 1'b0;
        n = 0;
        model_clear();
        check();
    endtask

    task automatic set_req(int who, bit wr, int line, int word);
        if (who == 0) begin
            A_WR = wr; A_LINE = 5'(line); A_WORD = 7'(word); A_REQ = 1'b1;
        end else begin
            C_WR = wr; C_LINE = 5'(line); C_WORD = 7'(word); C_REQ = 1'b1;
        end
    endtask

    // Step until both requesters were answered and the controller is idle;
    // each requester drops REQ once it sees its ACK or ERR.
    task automatic run_until_quiet(int bound, string tag);
        bit quiet;
        quiet = 1'b0;
        for (int k = 0; k < bound && !quiet; k++) begin
            cyc();
            if (A_ACK || A_ERR) A_REQ = 1'b0;
            if (C_ACK || C_ERR) C_REQ = 1'b0;
            if (!A_REQ && !C_REQ && n >= m_free_at + 2) quiet = 1'b1;
        end
        vectors++;
        assert (quiet) else begin
            miscompares++;
            $error("FAIL timeout_%s: got busy expected idle within %0d cycles", tag, bound);
        end
        A_REQ = 1'b0;
        C_REQ = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w, k;
        RESET = 1'b1;
        A_REQ = 0; A_WR = 0; A_LINE = 0; A_WORD = 0;
        C_REQ = 0; C_WR = 0; C_LINE = 0; C_WORD = 0;
        n = 0;
        model_clear();
        @(posedge CLOCK);
        #1;

        // One full revolution with no requests: BT/WT wrap back to 0/0.
        do_reset();
        repeat (3133) cyc();

        // C write line 8 word 5 from reset: ACK at 1, XFER 145..173, DONE 174.
        do_reset();
        set_req(1, 1'b1, 8, 5);
        run_until_quiet(400, "c_write");

        // Simultaneous pair after reset (A first), then A alone, then a pair
        // again where C is the one not granted last.
        do_reset();
        set_req(0, 1'($urandom_range(0, 1)), $urandom_range(7, 18), near_word(3));
        set_req(1, 1'($urandom_range(0, 1)), $urandom_range(7, 18), near_word(8));
        run_until_quiet(7000, "pair1");
        set_req(0, 1'($urandom_range(0, 1)), $urandom_range(7, 18), near_word(2));
        run_until_quiet(7000, "a_alone");
        set_req(0, 1'($urandom_range(0, 1)), $urandom_range(7, 18), near_word(6));
        set_req(1, 1'($urandom_range(0, 1)), $urandom_range(7, 18), near_word(3));
        run_until_quiet(7000, "pair2");

        // A read line 18 word 0 from reset: next revolution's WT 0.
        do_reset();
        set_req(0, 1'b0, 18, 0);
        run_until_quiet(3400, "a_read18");

        // Rejects: line 19, word 108, line 6.
        set_req(1, 1'b1, 19, 3);
        run_until_quiet(20, "err_line19");
        set_req(1, 1'b0, 8, 108);
        run_until_quiet(20, "err_word108");
        set_req(0, 1'b1, 6, 10);
        run_until_quiet(20, "err_line6");

        // Grant on BT 28 of word WORD-1: transfer waits a whole revolution.
        w = near_word(3);
        k = 0;
        while (!((n % 29 == 28) && ((n / 29) % 108 == (w + 107) % 108)) && k < 400) begin
            cyc();
            k++;
        end
        set_req(1, 1'b1, $urandom_range(7, 18), w);
        run_until_quiet(3500, "late_grant");

        // Reset at XFER BT 10 aborts without DONE (REQ held across the reset).
        set_req(0, 1'b1, $urandom_range(7, 18), near_word(2));
        k = 0;
        while (n != m_xs + 10 && k < 400) begin
            cyc();
            if (A_ACK) A_REQ = 1'b0;
            k++;
        end
        vectors++;
        assert (n == m_xs + 10) else begin
            miscompares++;
            $error("FAIL reach_xfer_bt10: got cyc %0d expected %0d", n, m_xs + 10);
        end
        A_REQ = 1'b1;
        do_reset();
        repeat (60) cyc();

        // Randomized mix of single, paired and out-of-range requests.
        for (int i = 0; i < 6; i++) begin
            int mode;
            mode = $urandom_range(0, 2);
            if (mode != 1)
                set_req(0, 1'($urandom_range(0, 1)), $urandom_range(5, 20),
                        ($urandom_range(0, 7) == 0) ? $urandom_range(108, 127)
                                                    : near_word($urandom_range(2, 5)));
            if (mode != 0)
                set_req(1, 1'($urandom_range(0, 1)), $urandom_range(5, 20),
                        ($urandom_range(0, 7) == 0) ? $urandom_range(108, 127)
                                                    : near_word($urandom_range(6, 9)));
            run_until_quiet(7000, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
